// File: rtl/l15_core_respdecoder.sv
// l15_core_respdecoder: steers L1.5 return packets into buffered I-fill / D-load channels and tracks outstanding loads/stores
module l15_core_respdecoder #(
  parameter int PADDR_W          = 40,
  parameter int LINE_BITS        = 256,
  parameter int SWAP_BYTES       = 1,
  parameter int MAX_LD           = 4,
  parameter int MAX_ST           = 4,
  parameter int LD_ST_ORDERED    = 1,
  parameter int INT_PULSE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 l15_val,
  input  logic [3:0]           l15_returntype,
  input  logic [1:0]           l15_error,
  input  logic [PADDR_W-1:0]   l15_address,
  input  logic [63:0]          l15_data_0,
  input  logic [63:0]          l15_data_1,
  input  logic [63:0]          l15_data_2,
  input  logic [63:0]          l15_data_3,
  output logic                 l15_ack,
  output logic                 ic_resp_valid,
  input  logic                 ic_resp_ready,
  output logic [PADDR_W-1:0]   ic_resp_addr,
  output logic [LINE_BITS-1:0] ic_resp_data,
  input  logic                 dc_ld_req,
  output logic                 dc_ld_req_ready,
  output logic                 dc_ld_resp_valid,
  input  logic                 dc_ld_resp_ready,
  output logic [PADDR_W-1:0]   dc_ld_resp_addr,
  output logic [LINE_BITS-1:0] dc_ld_resp_data,
  output logic [1:0]           dc_ld_resp_err,
  input  logic                 dc_st_req,
  output logic                 dc_st_complete,
  output logic                 dc_st_stall,
  output logic                 core_int,
  output logic                 unexpected_resp
);
  localparam int WORDS = LINE_BITS / 64;
  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam int LDW   = $clog2(MAX_LD + 1);
  localparam int STW   = $clog2(MAX_ST + 1);
  localparam int IW    = $clog2(INT_PULSE_CYCLES + 1);
  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] ST_ACK    = 4'b0100;
  localparam logic [3:0] INT_RET   = 4'b0111;

  function automatic logic [63:0] swap64(input logic [63:0] w);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[b*8+:8] = w[(7-b)*8+:8];
    return r;
  endfunction

  logic                 ic_valid_q, ic_valid_d, dc_valid_q, dc_valid_d;
  logic [PADDR_W-1:0]   ic_addr_q, ic_addr_d, dc_addr_q, dc_addr_d, addr_al;
  logic [LINE_BITS-1:0] ic_data_q, ic_data_d, dc_data_q, dc_data_d, line;
  logic [1:0]           dc_err_q, dc_err_d;
  logic [LDW-1:0]       ld_cnt_q, ld_cnt_d;
  logic [STW-1:0]       st_cnt_q, st_cnt_d;
  logic [IW-1:0]        int_cnt_q, int_cnt_d;
  logic                 st_done_q, st_done_d, unexp_q, unexp_d;
  logic                 is_ifill, is_load, is_st, is_int, accept;
  logic                 ic_take, dc_take, st_take, int_trig, ld_inc, ld_dec, st_inc, st_dec;
  logic [255:0]         raw;

  // line assembly: low words first, optional per-word byte reversal, line-aligned address
  always_comb begin
    raw  = {l15_data_3, l15_data_2, l15_data_1, l15_data_0};
    line = '0;
    for (int i = 0; i < WORDS; i++)
      line[i*64+:64] = (SWAP_BYTES != 0) ? swap64(raw[i*64+:64]) : raw[i*64+:64];
    addr_al = {l15_address[PADDR_W-1:OFF], {OFF{1'b0}}};
  end

  assign is_ifill        = l15_returntype == IFILL_RET;
  assign is_load         = l15_returntype == LOAD_RET;
  assign is_st           = l15_returntype == ST_ACK;
  assign is_int          = l15_returntype == INT_RET;
  assign accept          = is_ifill ? (~ic_valid_q | ic_resp_ready) :
                           is_load  ? (~dc_valid_q | dc_ld_resp_ready) : 1'b1;
  assign l15_ack         = l15_val & accept & ~rst;
  assign ic_take         = l15_ack & is_ifill;
  assign dc_take         = l15_ack & is_load;
  assign st_take         = l15_ack & is_st;
  assign int_trig        = l15_ack & is_int & (l15_data_0[17:16] == 2'b01);
  assign dc_ld_req_ready = ld_cnt_q < LDW'(MAX_LD);
  assign dc_st_stall     = (st_cnt_q == STW'(MAX_ST)) | ((LD_ST_ORDERED != 0) & ((ld_cnt_q != '0) | dc_ld_req));
  assign ld_inc          = dc_ld_req & dc_ld_req_ready;
  assign ld_dec          = dc_take & (ld_cnt_q != '0);
  assign st_inc          = dc_st_req & ~dc_st_stall;
  assign st_dec          = st_take & (st_cnt_q != '0);

  // next state for holding registers, counters, pulses and the sticky error flag
  always_comb begin
    ic_valid_d = ic_take | (ic_valid_q & ~ic_resp_ready);
    ic_addr_d  = ic_take ? addr_al : ic_addr_q;
    ic_data_d  = ic_take ? line : ic_data_q;
    dc_valid_d = dc_take | (dc_valid_q & ~dc_ld_resp_ready);
    dc_addr_d  = dc_take ? addr_al : dc_addr_q;
    dc_data_d  = dc_take ? line : dc_data_q;
    dc_err_d   = dc_take ? l15_error : dc_err_q;
    ld_cnt_d   = ld_cnt_q + LDW'(ld_inc) - LDW'(ld_dec);
    st_cnt_d   = st_cnt_q + STW'(st_inc) - STW'(st_dec);
    st_done_d  = st_take;
    int_cnt_d  = int_trig ? IW'(INT_PULSE_CYCLES) : int_cnt_q - IW'(int_cnt_q != '0);
    unexp_d    = unexp_q | (dc_take & (ld_cnt_q == '0)) | (st_take & (st_cnt_q == '0));
  end

  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_valid_q <= 1'b0;
      ic_addr_q  <= '0;
      ic_data_q  <= '0;
      dc_valid_q <= 1'b0;
      dc_addr_q  <= '0;
      dc_data_q  <= '0;
      dc_err_q   <= '0;
      ld_cnt_q   <= '0;
      st_cnt_q   <= '0;
      st_done_q  <= 1'b0;
      int_cnt_q  <= '0;
      unexp_q    <= 1'b0;
    end else begin
      ic_valid_q <= ic_valid_d;
      ic_addr_q  <= ic_addr_d;
      ic_data_q  <= ic_data_d;
      dc_valid_q <= dc_valid_d;
      dc_addr_q  <= dc_addr_d;
      dc_data_q  <= dc_data_d;
      dc_err_q   <= dc_err_d;
      ld_cnt_q   <= ld_cnt_d;
      st_cnt_q   <= st_cnt_d;
      st_done_q  <= st_done_d;
      int_cnt_q  <= int_cnt_d;
      unexp_q    <= unexp_d;
    end
  end

  assign ic_resp_valid    = ic_valid_q;
  assign ic_resp_addr     = ic_addr_q;
  assign ic_resp_data     = ic_data_q;
  assign dc_ld_resp_valid = dc_valid_q;
  assign dc_ld_resp_addr  = dc_addr_q;
  assign dc_ld_resp_data  = dc_data_q;
  assign dc_ld_resp_err   = dc_err_q;
  assign dc_st_complete   = st_done_q;
  assign core_int         = int_cnt_q != '0;
  assign unexpected_resp  = unexp_q;
endmodule

// File: tb/tb_l15_core_respdecoder.sv
// tb_l15_core_respdecoder: scoreboard bench for the L1.5 response decoder
module tb_l15_core_respdecoder;
  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] ST_ACK    = 4'b0100;
  localparam logic [3:0] INT_RET   = 4'b0111;
  localparam logic [3:0] OTHER_RET = 4'b1010;

  typedef struct {
    logic [39:0]  a;
    logic [255:0] d;
    logic [1:0]   e;
  } exp_t;

  logic         clk, rst, l15_val, l15_ack;
  logic [3:0]   l15_returntype;
  logic [1:0]   l15_error, dc_ld_resp_err;
  logic [39:0]  l15_address, ic_resp_addr, dc_ld_resp_addr;
  logic [63:0]  l15_data_0, l15_data_1, l15_data_2, l15_data_3;
  logic         ic_resp_valid, ic_resp_ready, dc_ld_req, dc_ld_req_ready;
  logic         dc_ld_resp_valid, dc_ld_resp_ready, dc_st_req, dc_st_complete, dc_st_stall;
  logic         core_int, unexpected_resp;
  logic [255:0] ic_resp_data, dc_ld_resp_data;

  exp_t ic_q[$], dc_q[$];
  exp_t ic_e, dc_e;
  int   nvec = 0, nbad = 0, w;

  l15_core_respdecoder #(.PADDR_W(40), .LINE_BITS(256), .SWAP_BYTES(1), .MAX_LD(4), .MAX_ST(4),
                         .LD_ST_ORDERED(1), .INT_PULSE_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .l15_val(l15_val), .l15_returntype(l15_returntype), .l15_error(l15_error),
    .l15_address(l15_address), .l15_data_0(l15_data_0), .l15_data_1(l15_data_1),
    .l15_data_2(l15_data_2), .l15_data_3(l15_data_3), .l15_ack(l15_ack),
    .ic_resp_valid(ic_resp_valid), .ic_resp_ready(ic_resp_ready), .ic_resp_addr(ic_resp_addr),
    .ic_resp_data(ic_resp_data), .dc_ld_req(dc_ld_req), .dc_ld_req_ready(dc_ld_req_ready),
    .dc_ld_resp_valid(dc_ld_resp_valid), .dc_ld_resp_ready(dc_ld_resp_ready),
    .dc_ld_resp_addr(dc_ld_resp_addr), .dc_ld_resp_data(dc_ld_resp_data),
    .dc_ld_resp_err(dc_ld_resp_err), .dc_st_req(dc_st_req), .dc_st_complete(dc_st_complete),
    .dc_st_stall(dc_st_stall), .core_int(core_int), .unexpected_resp(unexpected_resp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] rt, input logic [39:0] a, input logic [63:0] d0, input logic [1:0] e);
    exp_t x;
    logic [63:0] d1, d2, d3;
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    d3 = {$urandom, $urandom};
    x.a = {a[39:5], 5'b0};
    x.d = {{<<8{d3}}, {<<8{d2}}, {<<8{d1}}, {<<8{d0}}};
    x.e = e;
    if (rt == IFILL_RET) ic_q.push_back(x);
    if (rt == LOAD_RET) dc_q.push_back(x);
    l15_val = 1'b1;
    l15_returntype = rt;
    l15_address = a;
    l15_error = e;
    l15_data_0 = d0;
    l15_data_1 = d1;
    l15_data_2 = d2;
    l15_data_3 = d3;
  endtask

  task automatic send(input logic [3:0] rt, input logic [39:0] a, input logic [63:0] d0,
                      input logic [1:0] e, output int waited);
    drive(rt, a, d0, e);
    waited = 0;
    forever begin
      @(negedge clk);
      if (l15_ack) break;
      waited++;
      if (waited > 20) begin
        chk("ack_timeout", 0, 1);
        break;
      end
    end
    cyc();
    l15_val = 1'b0;
  endtask

  // scoreboard: pop expected lines as each channel hands off
  always @(negedge clk) begin
    if (!rst && ic_resp_valid && ic_resp_ready) begin
      if (ic_q.size() == 0) chk("ic_extra", 1, 0);
      else begin
        ic_e = ic_q.pop_front();
        chk("ic_addr", ic_resp_addr, ic_e.a);
        chk("ic_data", ic_resp_data, ic_e.d);
      end
    end
    if (!rst && dc_ld_resp_valid && dc_ld_resp_ready) begin
      if (dc_q.size() == 0) chk("dc_extra", 1, 0);
      else begin
        dc_e = dc_q.pop_front();
        chk("dc_addr", dc_ld_resp_addr, dc_e.a);
        chk("dc_data", dc_ld_resp_data, dc_e.d);
        chk("dc_err", dc_ld_resp_err, dc_e.e);
      end
    end
  end

  initial begin
    rst = 1'b1;
    l15_val = 1'b1;
    l15_returntype = OTHER_RET;
    l15_error = '0;
    l15_address = '0;
    {l15_data_0, l15_data_1, l15_data_2, l15_data_3} = '0;
    ic_resp_ready = 1'b0;
    dc_ld_resp_ready = 1'b0;
    dc_ld_req = 1'b0;
    dc_st_req = 1'b0;
    repeat (2) cyc();
    chk("rst_ack", l15_ack, 0);
    chk("rst_icv", ic_resp_valid, 0);
    chk("rst_dcv", dc_ld_resp_valid, 0);
    chk("rst_int", core_int, 0);
    chk("rst_stc", dc_st_complete, 0);
    chk("rst_unexp", unexpected_resp, 0);
    chk("rst_ldrdy", dc_ld_req_ready, 1);
    chk("rst_stall", dc_st_stall, 0);
    rst = 1'b0;
    l15_val = 1'b0;
    cyc();

    ic_resp_ready = 1'b1;
    dc_ld_resp_ready = 1'b1;
    send(IFILL_RET, 40'h00_8000_0047, 64'h0011223344556677, 2'b00, w);
    chk("ic_ack_lat", w, 0);
    chk("ic_valid", ic_resp_valid, 1);
    chk("ic_addr_al", ic_resp_addr, 40'h00_8000_0040);
    chk("ic_word0", ic_resp_data[63:0], 64'h7766554433221100);
    cyc();
    chk("ic_drain", ic_resp_valid, 0);
    send(OTHER_RET, 40'h123, 64'h1, 2'b00, w);
    chk("oth_ack", w, 0);
    chk("oth_icv", ic_resp_valid, 0);
    chk("oth_dcv", dc_ld_resp_valid, 0);

    ic_resp_ready = 1'b0;
    send(IFILL_RET, 40'h00_0000_1000, {$urandom, $urandom}, 2'b00, w);
    chk("bp_first_ack", w, 0);
    drive(IFILL_RET, 40'h00_0000_2020, {$urandom, $urandom}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_ack", l15_ack, 0);
      chk("bp_hold_vld", ic_resp_valid, 1);
      cyc();
    end
    ic_resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_ack", l15_ack, 1);
    cyc();
    l15_val = 1'b0;
    repeat (2) cyc();
    chk("bp_drained", ic_resp_valid, 0);

    dc_ld_req = 1'b1;
    repeat (3) cyc();
    send(LOAD_RET, 40'h00_4000_0008, {$urandom, $urandom}, 2'b10, w);
    chk("ld_cnt3_rdy", dc_ld_req_ready, 1);
    cyc();
    dc_ld_req = 1'b0;
    chk("ld_full", dc_ld_req_ready, 0);
    dc_ld_req = 1'b1;
    cyc();
    dc_ld_req = 1'b0;
    send(LOAD_RET, 40'h00_4000_0100, {$urandom, $urandom}, 2'b01, w);
    chk("ld_drain_rdy", dc_ld_req_ready, 1);
    for (int i = 0; i < 3; i++) send(LOAD_RET, 40'h00_4000_0200 + 40'(i * 32), {$urandom, $urandom}, 2'(i), w);
    chk("ld_empty_stall", dc_st_stall, 0);
    chk("ld_empty_unexp", unexpected_resp, 0);

    dc_ld_req = 1'b1;
    #1;
    chk("stall_req", dc_st_stall, 1);
    cyc();
    dc_ld_req = 1'b0;
    #1;
    chk("stall_ld1", dc_st_stall, 1);
    send(LOAD_RET, 40'h00_0000_0300, {$urandom, $urandom}, 2'b00, w);
    chk("stall_clear", dc_st_stall, 0);
    dc_st_req = 1'b1;
    cyc();
    dc_st_req = 1'b0;
    chk("st_one_stall", dc_st_stall, 0);
    send(ST_ACK, 40'h0, 64'h0, 2'b00, w);
    chk("st_cpl", dc_st_complete, 1);
    cyc();
    chk("st_cpl_end", dc_st_complete, 0);
    dc_st_req = 1'b1;
    repeat (4) cyc();
    dc_st_req = 1'b0;
    chk("st_full", dc_st_stall, 1);
    for (int i = 0; i < 4; i++) send(ST_ACK, 40'h0, 64'h0, 2'b00, w);
    chk("st_drained", dc_st_stall, 0);
    chk("st_unexp", unexpected_resp, 0);

    send(INT_RET, 40'h0, 64'h0000_0000_0001_0000, 2'b00, w);
    chk("int_p1", core_int, 1);
    cyc();
    chk("int_p2", core_int, 1);
    cyc();
    chk("int_p3", core_int, 1);
    cyc();
    chk("int_end", core_int, 0);
    send(INT_RET, 40'h0, 64'h0000_0000_0001_0000, 2'b00, w);
    chk("rt_p1", core_int, 1);
    cyc();
    chk("rt_p2", core_int, 1);
    send(INT_RET, 40'h0, 64'h0000_0000_0001_0000, 2'b00, w);
    chk("rt_x1", core_int, 1);
    cyc();
    chk("rt_x2", core_int, 1);
    cyc();
    chk("rt_x3", core_int, 1);
    cyc();
    chk("rt_end", core_int, 0);
    send(INT_RET, 40'h0, 64'h0000_0000_0002_0000, 2'b00, w);
    chk("int_code10_ack", w, 0);
    for (int i = 0; i < 3; i++) begin
      chk("int_code10", core_int, 0);
      cyc();
    end

    send(LOAD_RET, 40'h00_0bad_0010, {$urandom, $urandom}, 2'b11, w);
    chk("unexp_dlv", dc_ld_resp_valid, 1);
    chk("unexp_set", unexpected_resp, 1);
    chk("unexp_cnt0", dc_st_stall, 0);
    repeat (3) cyc();
    chk("unexp_sticky", unexpected_resp, 1);

    ic_resp_ready = 1'b0;
    send(IFILL_RET, 40'h00_0000_4000, {$urandom, $urandom}, 2'b00, w);
    send(INT_RET, 40'h0, 64'h0000_0000_0001_0000, 2'b00, w);
    drive(IFILL_RET, 40'h00_0000_5000, {$urandom, $urandom}, 2'b00);
    chk("pre_rst_int", core_int, 1);
    chk("pre_rst_icv", ic_resp_valid, 1);
    rst = 1'b1;
    #1;
    chk("arst_int", core_int, 0);
    chk("arst_icv", ic_resp_valid, 0);
    chk("arst_dcv", dc_ld_resp_valid, 0);
    chk("arst_ack", l15_ack, 0);
    chk("arst_unexp", unexpected_resp, 0);
    chk("arst_stc", dc_st_complete, 0);
    ic_q.delete();
    dc_q.delete();
    cyc();
    l15_val = 1'b0;
    rst = 1'b0;
    repeat (2) cyc();
    chk("ic_left", ic_q.size(), 0);
    chk("dc_left", dc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
